// File: rtl/cpu_pkg.sv
// Shared types and field positions for the multi-cycle sequencer and its ALU.
package cpu_pkg;

    localparam int PC_W    = 4;
    localparam int DATA_W  = 4;
    localparam int INSTR_W = 8;
    localparam int REG_AW  = 2;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS1_MSB = 3;
    localparam int RS1_LSB = 2;
    localparam int RS2_MSB = 1;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LDI  = 2'b10,
        OP_HALT = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit add/subtract; carry is bit 4 of the 5-bit sum or the borrow.
// Latency: 0 cycles; no backpressure.
module alu_4bit
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  opcode_t           op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = '0;
        result = b;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                // Bit 4 of the zero-extended difference is set exactly when a < b.
                sum    = {1'b0, a} - {1'b0, b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back controller driving a 4x4 register file.
// Latency: 4 cycles per ADD/SUB/LDI, HALT reached 2 cycles after its fetch; no backpressure.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [REG_AW-1:0]  rs1,
    output logic [REG_AW-1:0]  rs2,
    output logic [REG_AW-1:0]  rd,
    output logic               RegWrite,
    output logic [DATA_W-1:0]  WriteData,
    input  logic [DATA_W-1:0]  rd1,
    input  logic [DATA_W-1:0]  rd2,
    output logic               busy,
    output logic               halted,
    output logic               carry
);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               carry_q, carry_d;

    opcode_t            op;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_carry;

    assign op = opcode_t'(ir_q[OP_MSB:OP_LSB]);

    alu_4bit u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op),
        .result (alu_res),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = imem_rdata;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                a_d     = rd1;
                b_d     = rd2;
                state_d = (op == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                // LDI bypasses the ALU and leaves the carry flag untouched.
                if (op == OP_LDI) begin
                    result_d = ir_q[IMM_MSB:IMM_LSB];
                end else begin
                    result_d = alu_res;
                    carry_d  = alu_carry;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign rd        = ir_q[RD_MSB:RD_LSB];
    assign rs1       = ir_q[RS1_MSB:RS1_LSB];
    assign rs2       = ir_q[RS2_MSB:RS2_LSB];
    assign RegWrite  = (state_q == ST_WB);
    assign WriteData = result_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                       (state_q == ST_EXEC)  || (state_q == ST_WB);
    assign halted    = (state_q == ST_HALT);
    assign carry     = carry_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control and execute unit that drives the 4-entry × 4-bit register file as its initiator. It fetches 8-bit instructions from an external combinational instruction ROM and issues read addresses. It performs a 4-bit ALU operation, then issues the single write-back strobe per instruction. It sits between the instruction memory and the register file and is the only agent that writes registers.

## Interface
- PC_W, 4, program-counter / instruction-address width (16-entry ROM)
- DATA_W, 4, data width; must equal register-file width
- INSTR_W, 8, instruction width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock domain only
- start  in  1  single-cycle pulse; honoured only in IDLE
- imem_addr  out  PC_W  instruction address (= PC)
- imem_rdata  in  INSTR_W  instruction word, valid same cycle as imem_addr
- rs1, rs2, rd  out  2  register-file read/write addresses
- RegWrite  out  1  register-file write enable
- WriteData  out  DATA_W  register-file write data
- rd1, rd2  in  DATA_W  register-file read data (combinational)
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- halted  out  1  high in HALT
- carry  out  1  carry/borrow flag

## Operation
- Instruction fields: op=IR[7:6], rd=IR[5:4], rs1=IR[3:2], rs2=IR[1:0], imm=IR[3:0].
- Opcodes:
  - 00 ADD: rd←rs1+rs2; carry←bit 4 of the 5-bit sum.
  - 01 SUB: rd←rs1−rs2 mod 16; carry←1 iff rs1<rs2 (borrow).
  - 10 LDI: rd←imm; carry unchanged.
  - 11 HALT.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: on start=1 → FETCH; otherwise stay.
- FETCH: IR←imem_rdata; → DECODE.
- DECODE: A←rd1, B←rd2; → HALT if op=11, otherwise → EXEC.
- EXEC: result and next-carry latched; → WB.
- WB: RegWrite=1, rd=IR rd, WriteData=result; PC←PC+1 (15 wraps to 0); → FETCH.
- HALT: terminal; left only by reset. PC holds the HALT instruction's address.
- rs1, rs2 and rd are driven continuously from the IR fields. RegWrite is high only in WB.
- start is ignored outside IDLE.

## Timing
- Reset values: state=IDLE, PC=0, IR=0, A=B=result=0, carry=0. Outputs are imem_addr=0, rs1=rs2=rd=0, RegWrite=0, WriteData=0, busy=0, halted=0.
- Reset is asynchronous: asserting it mid-instruction (including in WB) drops RegWrite immediately, and no partial write completes.
- Start pulse sampled at edge N gives FETCH in cycle N+1.
- Each ALU/LDI instruction takes exactly 4 cycles (FETCH, DECODE, EXEC, WB).
- HALT takes 2 cycles, then halted=1 from the third cycle.
- The register write lands on the edge leaving WB. The next instruction's DECODE therefore sees the updated value, so there is no hazard and no forwarding.
- carry updates on the edge leaving EXEC (ADD/SUB only).
- Width rule: the ALU computes 5 bits; bits [3:0] go to the result and bit 4 (or the borrow) goes to carry.

## Structure
- Package cpu_pkg holds:
  - opcode_t enum (OP_ADD, OP_SUB, OP_LDI, OP_HALT);
  - state_t enum for the six states;
  - PC_W, DATA_W, INSTR_W constants and the field-slice positions.
- One sub-module, alu_4bit: combinational; inputs a, b, op; outputs result[3:0] and carry.
- The FSM, PC, IR and operand/result registers stay in cpu_sequencer.

## Test plan
- Basic program.
  - ROM: 0x95, 0xA3, 0x36, 0xC0 (LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT).
  - Pulse start.
  - Expect three RegWrite pulses: (rd=1, 5), (rd=2, 3), (rd=3, 8).
  - Expect carry=0, halted=1 at 14 cycles after the start edge, imem_addr=3.
- Carry/borrow.
  - ROM: 0x9F, 0xA1, 0x06, 0x79, 0xC0.
  - Expect writes (1, 15), (2, 1), then (0, 0) with carry=1, then (3, 2) with carry=1.
- PC wrap.
  - ROM: 16 LDI instructions, no HALT.
  - Expect imem_addr to step 0…15, then 0 again after the 16th WB.
  - Expect busy to stay 1.
- Start while busy.
  - Pulse start during EXEC of the first instruction.
  - Expect no state or PC disturbance; the write sequence is identical to the basic program.
- Reset mid-write.
  - Assert reset in WB of ADD.
  - Expect RegWrite=0 in the same cycle and all outputs at reset values.
  - Expect IDLE after release, with start required to restart.
- Idle hold.
  - No start for 20 cycles after reset.
  - Expect busy=0, RegWrite never asserted, imem_addr=0.
